// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI master sequencer
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } spi_state_t;

    localparam int DEF_SIZE    = 8;
    localparam int DEF_CLK_DIV = 2;

    // Only mode 0 is implemented; kept for a later CPOL/CPHA extension.
    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

    function automatic int div_cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - request/strobe bundle between host logic, controller and shift datapath
interface spi_master_ctrl_if;
    logic Start;
    logic Busy;
    logic Done;
    logic SS_n;
    logic SClk;
    logic LoadTx;
    logic EnTx;
    logic EnRx;

    modport master (
        input  Start,
        output Busy, Done, SS_n, SClk, LoadTx, EnTx, EnRx
    );

    modport slave (
        output Start,
        input  Busy, Done, SS_n, SClk, LoadTx, EnTx, EnRx
    );
endinterface

// File: rtl/spi_tick_gen.sv
// rtl/spi_tick_gen.sv - enabled divider emitting a one-cycle tick every CLK_DIV cycles
module spi_tick_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic En,
    output logic Tick
);
    localparam int            CW   = div_cnt_width(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q <= '0;
        end else if (!En || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign Tick = En && (cnt_q == LAST);

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - mode-0 SPI master sequencer: SClk/SS_n generation and shift strobes
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int SIZE    = DEF_SIZE,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic               Clk,
    input  logic               Rst_n,
    spi_master_ctrl_if.master  bus
);
    localparam int            TW        = $clog2(2 * SIZE + 1);
    localparam logic [TW-1:0] LAST_TOGL = TW'(2 * SIZE - 1);

    spi_state_t    state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          start_q;
    logic          busy_q, busy_d, done_q, done_d, ss_n_q, ss_n_d, sclk_q, sclk_d;
    logic          load_q, load_d, entx_q, entx_d, enrx_q, enrx_d;
    logic          tick_en, tick;

    assign tick_en = (state_q == SETUP) || (state_q == XFER) || (state_q == HOLD);

    spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .En    (tick_en),
        .Tick  (tick)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ss_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            load_q  <= 1'b0;
            entx_q  <= 1'b0;
            enrx_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            start_q <= bus.Start;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ss_n_q  <= ss_n_d;
            sclk_q  <= sclk_d;
            load_q  <= load_d;
            entx_q  <= entx_d;
            enrx_q  <= enrx_d;
        end
    end

    // Strobes are computed from the transition being taken so they land on the SClk edge itself.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        sclk_d  = sclk_q;
        load_d  = 1'b0;
        entx_d  = 1'b0;
        enrx_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tcnt_d = '0;
                if (start_q) begin
                    state_d = SETUP;
                    load_d  = 1'b1;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = XFER;
                    sclk_d  = 1'b1;
                    enrx_d  = 1'b1;
                    tcnt_d  = TW'(1);
                end
            end
            XFER: begin
                if (tick) begin
                    tcnt_d = tcnt_q + TW'(1);
                    if (tcnt_q == LAST_TOGL) begin
                        state_d = HOLD;
                        sclk_d  = 1'b0;
                    end else begin
                        sclk_d = ~sclk_q;
                        enrx_d = ~sclk_q;
                        entx_d = sclk_q;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        ss_n_d = !((state_d == SETUP) || (state_d == XFER) || (state_d == HOLD));
    end

    assign bus.Busy   = busy_q;
    assign bus.Done   = done_q;
    assign bus.SS_n   = ss_n_q;
    assign bus.SClk   = sclk_q;
    assign bus.LoadTx = load_q;
    assign bus.EnTx   = entx_q;
    assign bus.EnRx   = enrx_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - self-checking bench for spi_master_ctrl with timing model and loopback
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    spi_master_ctrl_if bus_a ();
    spi_master_ctrl_if bus_b ();

    spi_master_ctrl #(.SIZE(8), .CLK_DIV(2)) dut_a (.Clk(clk), .Rst_n(rst_n), .bus(bus_a));
    spi_master_ctrl #(.SIZE(4), .CLK_DIV(1)) dut_b (.Clk(clk), .Rst_n(rst_n), .bus(bus_b));

    // {Busy, Done, SS_n, SClk, LoadTx, EnTx, EnRx}
    localparam logic [6:0] IDLE_VEC = 7'b0010000;
    logic [6:0] obs [2];
    assign obs[0] = {bus_a.Busy, bus_a.Done, bus_a.SS_n, bus_a.SClk, bus_a.LoadTx, bus_a.EnTx, bus_a.EnRx};
    assign obs[1] = {bus_b.Busy, bus_b.Done, bus_b.SS_n, bus_b.SClk, bus_b.LoadTx, bus_b.EnTx, bus_b.EnRx};

    // External shift datapath, MOSI looped back to MISO
    logic [7:0] tx_val [2];
    logic [7:0] tx_sr  [2];
    logic [7:0] rx_sr  [2];

    always @(posedge clk) begin
        if (bus_a.LoadTx) tx_sr[0] <= tx_val[0];
        else if (bus_a.EnTx) tx_sr[0] <= tx_sr[0] << 1;
        if (bus_a.EnRx) rx_sr[0] <= {rx_sr[0][6:0], tx_sr[0][7]};
        if (bus_b.LoadTx) tx_sr[1] <= tx_val[1];
        else if (bus_b.EnTx) tx_sr[1] <= tx_sr[1] << 1;
        if (bus_b.EnRx) rx_sr[1] <= {rx_sr[1][6:0], tx_sr[1][3]};
    end

    task automatic set_start(input int d, input logic v);
        if (d == 0) bus_a.Start = v;
        else        bus_b.Start = v;
    endtask

    // Expected outputs t edges after Start was sampled, straight from the edge-timing formulas.
    function automatic logic [6:0] model(input int t, input int s, input int dv);
        int   tend;
        int   r;
        logic busy, done, ss_n, sclk, ld, etx, erx;
        tend = 1 + (2 * s + 1) * dv;
        busy = (t >= 1) && (t <= tend);
        done = (t == tend);
        ss_n = !((t >= 1) && (t < tend));
        ld   = (t == 1);
        sclk = 1'b0;
        etx  = 1'b0;
        erx  = 1'b0;
        for (int n = 0; n < s; n++) begin
            r = 1 + (2 * n + 1) * dv;
            if (t >= r && t < r + dv) sclk = 1'b1;
            if (t == r) erx = 1'b1;
            if (n < s - 1 && t == r + dv) etx = 1'b1;
        end
        return {busy, done, ss_n, sclk, ld, etx, erx};
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Entry: at a negedge with Start already high (t0=0) or already sampled one edge ago (t0=1).
    task automatic run_xfer(input int d, input int s, input int dv, input bit hold, input int t0,
                            input string name, output int done_t);
        int         tend, nrx, ntx, nrise, bad_t;
        logic [6:0] o, e, bad_o, bad_e;
        logic       sclk_prev;
        logic [7:0] mask;
        tend = 1 + (2 * s + 1) * dv;
        nrx = 0; ntx = 0; nrise = 0; bad_t = -1; done_t = -1; sclk_prev = 1'b0;
        bad_o = '0; bad_e = '0;
        mask = 8'((1 << s) - 1);
        if (t0 == 1 && !hold) set_start(d, 1'b0);
        for (int t = t0; t <= tend + 1; t++) begin
            @(posedge clk);
            @(negedge clk);
            if (!hold) set_start(d, 1'b0);
            o = obs[d];
            e = model(t, s, dv);
            if (o !== e && bad_t < 0) begin
                bad_t = t; bad_o = o; bad_e = e;
            end
            if (o[0]) nrx++;
            if (o[1]) ntx++;
            if (o[3] && !sclk_prev) nrise++;
            sclk_prev = o[3];
            if (o[5]) done_t = t;
        end
        n_checks++;
        if (bad_t >= 0) begin
            n_fail++;
            $display("FAIL %s waveform edge=%0d got=%b want=%b", name, bad_t, bad_o, bad_e);
        end
        n_checks++;
        if (done_t !== tend) begin
            n_fail++;
            $display("FAIL %s done_edge got=%0d want=%0d", name, done_t, tend);
        end
        n_checks++;
        if (nrx !== s) begin
            n_fail++;
            $display("FAIL %s enrx_count got=%0d want=%0d", name, nrx, s);
        end
        n_checks++;
        if (ntx !== s - 1) begin
            n_fail++;
            $display("FAIL %s entx_count got=%0d want=%0d", name, ntx, s - 1);
        end
        n_checks++;
        if (nrise !== s) begin
            n_fail++;
            $display("FAIL %s sclk_periods got=%0d want=%0d", name, nrise, s);
        end
        n_checks++;
        if ((rx_sr[d] & mask) !== (tx_val[d] & mask)) begin
            n_fail++;
            $display("FAIL %s rx_data got=%h want=%h", name, rx_sr[d] & mask, tx_val[d] & mask);
        end
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        rst_n = 1'b0;
        idle_cycles(3);
        n_checks++;
        if (obs[0] !== IDLE_VEC || obs[1] !== IDLE_VEC) begin
            n_fail++;
            $display("FAIL reset_values got=%b/%b want=%b", obs[0], obs[1], IDLE_VEC);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (obs[0] !== IDLE_VEC || obs[1] !== IDLE_VEC) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL idle_hold bad_cycles got=%0d want=0 last=%b/%b", bad, obs[0], obs[1]);
        end
    endtask

    task automatic test_basic();
        int dt;
        tx_val[0] = 8'hA5;
        set_start(0, 1'b1);
        run_xfer(0, 8, 2, 1'b0, 0, "basic_a5", dt);
    endtask

    task automatic test_div1();
        int dt;
        tx_val[1] = 8'h09;
        @(negedge clk);
        set_start(1, 1'b1);
        run_xfer(1, 4, 1, 1'b0, 0, "div1", dt);
        n_checks++;
        if (dt !== 10) begin
            n_fail++;
            $display("FAIL div1_done_latency got=%0d want=10", dt);
        end
    endtask

    task automatic test_random();
        int dt;
        for (int i = 0; i < 4; i++) begin
            idle_cycles($urandom_range(0, 3));
            tx_val[0] = 8'($urandom_range(0, 255));
            set_start(0, 1'b1);
            run_xfer(0, 8, 2, 1'b0, 0, "rand_a", dt);
            idle_cycles($urandom_range(0, 3));
            tx_val[1] = 8'($urandom_range(0, 15));
            set_start(1, 1'b1);
            run_xfer(1, 4, 1, 1'b0, 0, "rand_b", dt);
        end
    endtask

    task automatic test_back_to_back();
        int dt, extra;
        extra = 0;
        @(negedge clk);
        tx_val[0] = 8'($urandom_range(0, 255));
        set_start(0, 1'b1);
        run_xfer(0, 8, 2, 1'b1, 0, "b2b_first", dt);
        tx_val[0] = 8'($urandom_range(0, 255));
        run_xfer(0, 8, 2, 1'b0, 1, "b2b_second", dt);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (obs[0] !== IDLE_VEC) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL b2b_no_third got=%0d busy_cycles want=0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int   dt, seen_done;
        seen_done = 0;
        @(negedge clk);
        tx_val[0] = 8'h3C;
        set_start(0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(0, 1'b0);
        // Third rise lands 11 edges after Start is sampled
        for (int t = 1; t <= 11; t++) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_checks++;
        if (obs[0][3] !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_sclk_high got=%b want=1", obs[0][3]);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs[0] !== IDLE_VEC) begin
            n_fail++;
            $display("FAIL rstmid_async got=%b want=%b", obs[0], IDLE_VEC);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (obs[0][5]) seen_done++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (obs[0] !== IDLE_VEC) seen_done++;
        end
        n_checks++;
        if (seen_done != 0) begin
            n_fail++;
            $display("FAIL rstmid_quiet got=%0d bad_cycles want=0", seen_done);
        end
        tx_val[0] = 8'($urandom_range(0, 255));
        set_start(0, 1'b1);
        run_xfer(0, 8, 2, 1'b0, 0, "rstmid_fresh", dt);
    endtask

    initial begin
        bus_a.Start = 1'b0;
        bus_b.Start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tx_val[i] = '0;
            tx_sr[i]  = '0;
            rx_sr[i]  = '0;
        end
        test_reset();
        test_basic();
        test_div1();
        test_random();
        test_back_to_back();
        test_reset_mid();
        idle_cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
